// File: rtl/led_bank_scanner.sv
// Time-multiplexed LED bank driver: sequences active-low buffer enables over a shared
// pre-inverted 8-bit bus, with blanking gaps and a req/ack snapshot at each frame start.
module led_bank_scanner #(
    parameter int NUM_BANKS    = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         enable,
    input  logic [NUM_BANKS*8-1:0]       bank_data,
    input  logic                         update_req,
    output logic                         update_ack,
    output logic [7:0]                   led_bus,
    output logic [NUM_BANKS-1:0]         bank_oe_n,
    output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
    output logic                         frame_done
);

    localparam int SEL_W   = $clog2(NUM_BANKS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);

    if (NUM_BANKS < 2 || NUM_BANKS > 16) begin : g_bad_banks
        $fatal(1, "led_bank_scanner: NUM_BANKS=%0d outside 2..16", NUM_BANKS);
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $fatal(1, "led_bank_scanner: DWELL_CYCLES=%0d must be >= 1", DWELL_CYCLES);
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $fatal(1, "led_bank_scanner: BLANK_CYCLES=%0d must be >= 1", BLANK_CYCLES);
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_DRIVE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     sel_d;
    logic [7:0]           shadow [NUM_BANKS];
    logic [NUM_BANKS-1:0] oe_d;
    logic                 capture;

    // cnt holds the cycles remaining in the current state after this one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = bank_sel;
        case (state_q)
            S_IDLE: begin
                sel_d = '0;
                cnt_d = '0;
                if (enable) state_d = S_LOAD;
            end
            S_LOAD: begin
                sel_d   = '0;
                state_d = S_BLANK;
                cnt_d   = CNT_W'(BLANK_CYCLES - 1);
            end
            S_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_DRIVE;
                    cnt_d   = CNT_W'(DWELL_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bank_sel == LAST_BANK) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = enable ? S_LOAD : S_IDLE;
                end else begin
                    sel_d   = bank_sel + SEL_W'(1);
                    state_d = S_BLANK;
                    cnt_d   = CNT_W'(BLANK_CYCLES - 1);
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        oe_d = '1;
        if (state_d == S_DRIVE) oe_d[sel_d] = 1'b0;
    end

    assign capture = (state_d == S_LOAD) && update_req;

    // Outputs are registered from the next-state view so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bank_sel   <= '0;
            bank_oe_n  <= '1;
            led_bus    <= 8'hFF;
            update_ack <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < NUM_BANKS; k++) shadow[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_sel   <= sel_d;
            bank_oe_n  <= oe_d;
            update_ack <= capture;
            frame_done <= (state_d == S_DRIVE) && (cnt_d == '0) && (sel_d == LAST_BANK);
            led_bus    <= (state_d == S_BLANK || state_d == S_DRIVE) ? ~shadow[sel_d] : 8'hFF;
            if (capture) begin
                for (int k = 0; k < NUM_BANKS; k++) shadow[k] <= bank_data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_led_bank_scanner.sv
// Directed bench for led_bank_scanner (2 banks, dwell 4, blank 2) plus an invariant
// sweep over random stimulus on both the small and the default-parameter instance.
module tb_led_bank_scanner;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [15:0] bank_data;
    logic        update_req;
    logic        update_ack;
    logic [7:0]  led_bus;
    logic [1:0]  bank_oe_n;
    logic [0:0]  bank_sel;
    logic        frame_done;

    logic [31:0] bank_data2;
    logic        update_ack2;
    logic [7:0]  led_bus2;
    logic [3:0]  bank_oe_n2;
    logic [1:0]  bank_sel2;
    logic        frame_done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_bank_scanner #(.NUM_BANKS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .bank_data(bank_data),
        .update_req(update_req), .update_ack(update_ack), .led_bus(led_bus),
        .bank_oe_n(bank_oe_n), .bank_sel(bank_sel), .frame_done(frame_done)
    );

    led_bank_scanner dut2 (
        .clk(clk), .nrst(nrst), .enable(enable), .bank_data(bank_data2),
        .update_req(update_req), .update_ack(update_ack2), .led_bus(led_bus2),
        .bank_oe_n(bank_oe_n2), .bank_sel(bank_sel2), .frame_done(frame_done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        total++; if (bank_oe_n !== 2'b11) begin bad++; $display("FAIL %s oe got=%b want=11", tag, bank_oe_n); end
        total++; if (led_bus !== 8'hFF) begin bad++; $display("FAIL %s led got=%h want=ff", tag, led_bus); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL %s sel got=%0d want=0", tag, bank_sel); end
        total++; if (update_ack !== 1'b0) begin bad++; $display("FAIL %s ack got=%b want=0", tag, update_ack); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL %s fd got=%b want=0", tag, frame_done); end
    endtask

    // One full frame: k=1 is LOAD, k=2..3 blank b0, 4..7 drive b0, 8..9 blank b1, 10..13 drive b1
    task automatic run_frame(input string tag, input logic ack_e, input logic [7:0] l0,
                             input logic [7:0] l1, input int raise_k, input int drop_k);
        logic [1:0] oe_e;
        logic [7:0] led_e;
        logic       sel_e, fd_e, ack_x;
        for (int k = 1; k <= 13; k++) begin
            step();
            oe_e  = (k >= 4 && k <= 7) ? 2'b10 : (k >= 10) ? 2'b01 : 2'b11;
            led_e = (k == 1) ? 8'hFF : (k <= 7) ? l0 : l1;
            sel_e = (k >= 8);
            fd_e  = (k == 13);
            ack_x = (k == 1) ? ack_e : 1'b0;
            total++; if (bank_oe_n !== oe_e) begin bad++; $display("FAIL %s oe k=%0d got=%b want=%b", tag, k, bank_oe_n, oe_e); end
            total++; if (led_bus !== led_e) begin bad++; $display("FAIL %s led k=%0d got=%h want=%h", tag, k, led_bus, led_e); end
            total++; if (bank_sel !== sel_e) begin bad++; $display("FAIL %s sel k=%0d got=%0d want=%0d", tag, k, bank_sel, sel_e); end
            total++; if (frame_done !== fd_e) begin bad++; $display("FAIL %s fd k=%0d got=%b want=%b", tag, k, frame_done, fd_e); end
            total++; if (update_ack !== ack_x) begin bad++; $display("FAIL %s ack k=%0d got=%b want=%b", tag, k, update_ack, ack_x); end
            if (k == 1) update_req = 1'b0;
            if (k == raise_k) update_req = 1'b1;
            if (k == drop_k) enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; enable = 1'b0; update_req = 1'b0; bank_data = '0; bank_data2 = '0;
        step();
        step();
        check_idle("reset");
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("idle_hold");
        end
    endtask

    task automatic test_basic_scan();
        bank_data = 16'h3CA5; update_req = 1'b1; enable = 1'b1;
        run_frame("basic", 1'b1, 8'h5A, 8'hC3, 0, 0);
    endtask

    task automatic test_snapshot();
        bank_data = 16'hFFFF;
        run_frame("iso_f2", 1'b0, 8'h5A, 8'hC3, 0, 0);
        run_frame("iso_f3", 1'b0, 8'h5A, 8'hC3, 6, 0);
        run_frame("newdata", 1'b1, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic test_disable();
        run_frame("disable", 1'b0, 8'h00, 8'h00, 0, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("post_disable");
        end
    endtask

    task automatic test_reset_mid_drive();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step();
        total++; if (bank_oe_n !== 2'b01) begin bad++; $display("FAIL pre_rst oe got=%b want=01", bank_oe_n); end
        total++; if (led_bus !== 8'h00) begin bad++; $display("FAIL pre_rst led got=%h want=00", led_bus); end
        nrst = 1'b0;
        step();
        check_idle("mid_rst");
        nrst = 1'b1;
        run_frame("after_rst", 1'b0, 8'hFF, 8'hFF, 0, 0);
    endtask

    task automatic test_invariants();
        int prev1 = -1;
        int prev2 = -1;
        int z1, z2;
        for (int c = 0; c < 10000; c++) begin
            enable     = ($urandom_range(0, 9) != 0);
            update_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bank_data  = 16'($urandom);
                bank_data2 = $urandom;
            end
            step();
            z1 = -1;
            for (int b = 0; b < 2; b++) if (bank_oe_n[b] == 1'b0) z1 = b;
            z2 = -1;
            for (int b = 0; b < 4; b++) if (bank_oe_n2[b] == 1'b0) z2 = b;
            total++; if ($countones(~bank_oe_n) > 1) begin bad++; $display("FAIL inv_onehot1 c=%0d got=%b want<=1zero", c, bank_oe_n); end
            total++; if ($countones(~bank_oe_n2) > 1) begin bad++; $display("FAIL inv_onehot2 c=%0d got=%b want<=1zero", c, bank_oe_n2); end
            total++; if (z1 >= 0 && prev1 >= 0 && z1 != prev1) begin bad++; $display("FAIL inv_gap1 c=%0d got=%0d->%0d want=blank", c, prev1, z1); end
            total++; if (z2 >= 0 && prev2 >= 0 && z2 != prev2) begin bad++; $display("FAIL inv_gap2 c=%0d got=%0d->%0d want=blank", c, prev2, z2); end
            prev1 = z1;
            prev2 = z2;
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_disable();
        test_reset_mid_drive();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
